// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16 -- 16-requester round-robin arbiter with single-owner grants.
//
// A two-state FSM (StIdle / StGrant) hands the resource to one requester at a
// time. In StIdle the first asserted request at or after the priority pointer
// (wrapping modulo 16) wins and is granted on the next edge. The grant is held
// while the owner keeps req high and en stays high. On release the pointer
// moves to owner+1 and at least one idle cycle always separates two grants.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, an 8-bit hold counter force-releases an owner after MAX_HOLD
//   consecutive grant cycles and pulses timeout for the following idle cycle.
//   When undefined, no counter is built and timeout is tied low.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles per owner (2..255), timeout build only
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   en       arbiter enable; low blocks new grants and releases the current one
//   req      per-requester level request
//   out      registered one-hot grant, zero when no grant
//   idx      registered index of the current/last granted requester
//   valid    high exactly while a grant is held
//   timeout  one-cycle pulse after a forced release
module rr_arbiter_16 #(
   parameter int unsigned MAX_HOLD = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [15:0] req,
   output logic [15:0] out,
   output logic [3:0]  idx,
   output logic        valid,
   output logic        timeout
);

   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("rr_arbiter_16: MAX_HOLD must be in 2..255");
   end

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [15:0] out_q, out_d;
   logic [3:0]  pick;
   logic        pick_found;
   logic [3:0]  cand;

`ifdef ARB_TIMEOUT_EN
   logic [7:0]  hold_q, hold_d;
   logic        timeout_q, timeout_d;
   logic        hold_expired;

   // Counter starts at 0 on the first grant cycle, so MAX_HOLD-1 marks the last one.
   assign hold_expired = (hold_q == 8'(MAX_HOLD - 1));
`endif

   // Round-robin search: first asserted request at ptr, ptr+1, ... wrapping modulo 16.
   always_comb begin
      pick       = ptr_q;
      pick_found = 1'b0;
      cand       = ptr_q;
      for (int i = 0; i < 16; i++) begin
         cand = ptr_q + 4'(i);
         if (!pick_found && req[cand]) begin
            pick       = cand;
            pick_found = 1'b1;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= 4'h0;
         ptr_q   <= 4'h0;
         out_q   <= 16'h0000;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         out_q   <= out_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q    <= 8'h00;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end
`endif

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
      hold_d    = hold_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         StIdle: begin
            if (en && pick_found) begin
               state_d = StGrant;
               idx_d   = pick;
`ifdef ARB_TIMEOUT_EN
               hold_d  = 8'h00;
`endif
            end
         end
         StGrant: begin
            if (!en || !req[idx_q]) begin
               state_d = StIdle;
               ptr_d   = idx_q + 4'd1;
`ifdef ARB_TIMEOUT_EN
            end else if (hold_expired) begin
               state_d   = StIdle;
               ptr_d     = idx_q + 4'd1;
               timeout_d = 1'b1;
            end else begin
               hold_d = hold_q + 8'd1;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output logic: grant vector is decoded from the next state so it is registered.
   always_comb begin
      out_d = 16'h0000;
      if (state_d == StGrant) begin
         out_d = 16'h0001 << idx_d;
      end
   end

   assign out   = out_q;
   assign idx   = idx_q;
   assign valid = (state_q == StGrant);
`ifdef ARB_TIMEOUT_EN
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: doc/rr_arbiter_16.md
RR_ARBITER_16 -- requirements
Module: rr_arbiter_16

Interface
REQ-001 SHALL have parameter: MAX_HOLD, 64, maximum consecutive grant cycles per holder (used only when ARB_TIMEOUT_EN is defined; legal range 2..255).
REQ-002 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: en  input  1  arbiter enable; low blocks new grants and releases the current one.
REQ-005 SHALL have port: req  input  16  per-requester request, level-sensitive, held high for the whole transaction.
REQ-006 SHALL have port: out  output  16  one-hot grant (decoded idx), registered, all-zero when no grant.
REQ-007 SHALL have port: idx  output  4  index of current/last granted requester, registered.
REQ-008 SHALL have port: valid  output  1  high exactly when out is non-zero.
REQ-009 SHALL have port: timeout  output  1  one-cycle pulse when a grant is force-released.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one requester owns the resource).
REQ-011 SHALL hold a 4-bit priority pointer ptr; search order ptr, ptr+1, ..., ptr+15 modulo 16.
REQ-012 In IDLE with en=1 and req!=0, SHALL select the first requester set in search order and enter GRANT on the next edge; out/idx/valid reflect it from that edge (1-cycle request-to-grant latency).
REQ-013 In IDLE with en=0 or req=0, SHALL remain in IDLE with out=0, valid=0, idx unchanged.
REQ-014 In GRANT, SHALL keep out, idx constant while req[idx]=1 and en=1.
REQ-015 In GRANT, SHALL return to IDLE on the next edge when req[idx]=0 or en=0; on that transition ptr SHALL become idx+1 (15 wraps to 0).
REQ-016 SHALL insert exactly one IDLE cycle between consecutive grants (no back-to-back grant without a zero cycle on out).
REQ-017 Requests from non-granted requesters SHALL NOT affect out during GRANT.
REQ-018 A requester dropping and re-raising req while not granted SHALL simply be re-evaluated at the next IDLE cycle; no request memory is kept.
REQ-019 out SHALL always equal the 4-to-16 one-hot decode of idx when valid=1, and 16'h0000 when valid=0.

Reset
REQ-020 On rst_n=0, asynchronously: state=IDLE, out=16'h0000, idx=4'h0, valid=0, timeout=0, ptr=4'h0, hold counter=0.
REQ-021 Reset asserted mid-GRANT SHALL drop the grant immediately, without waiting for a clock.
REQ-022 After rst_n deassertion, the first grant decision SHALL occur on the first rising edge with en=1 and req!=0.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN SHALL select the hold-timeout feature.
REQ-024 With ARB_TIMEOUT_EN defined: an 8-bit hold counter SHALL clear on GRANT entry and increment each GRANT cycle; when it reaches MAX_HOLD-1 with req[idx]=1 and en=1, the FSM SHALL enter IDLE on the next edge, ptr=idx+1, and timeout SHALL pulse high for that one cycle.
REQ-025 Without ARB_TIMEOUT_EN: no counter SHALL be built, grants last until req[idx] or en falls, and timeout SHALL be tied to 0.

Verification
REQ-026 Reset, en=1, req=16'h0001 -> after 1 edge out=16'h0001, idx=0, valid=1; drop req -> next edge out=0, ptr=1.
REQ-027 req=16'hFFFF held, each holder drops req after 2 grant cycles -> grant order idx 0,1,2,...,15,0 with one zero cycle between grants.
REQ-028 ptr=14, req=16'h0009 -> grant idx=0 (wrap past 15), then idx=3 on the following grant.
REQ-029 Grant idx=5 active, en driven 0 -> next edge out=0, valid=0; en=1 with req=16'h0020 -> idx=5 regranted only if no other requester ahead of ptr=6.
REQ-030 ARB_TIMEOUT_EN, MAX_HOLD=4, req=16'h0003 held -> idx=0 for 4 cycles, timeout=1 for one cycle, then idx=1; without macro idx=0 held indefinitely, timeout=0; rst_n pulsed low mid-grant -> out=0 immediately.
